mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
Memory-stage controller between the pipelined MIPS datapath's MEM-stage outputs and a multi-cycle single-port data bus. It accepts loads and stores from the EX/MEM register. Stores retire through a small posted write buffer; loads forward from that buffer or issue on the bus. It drives a stall to the hazard logic while a load or a full-buffer store is pending, and delivers load data to the MEM/WB register.

Parameters:
WBUF_DEPTH, 2, posted-write buffer entries; power of two, >=2
DATA_W, 32, data and address width

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  synchronous, active-low reset
mem_read_i  in  1  MEM-stage load (mem_to_reg of the instruction in MEM)
enable_wmem_i  in  1  MEM-stage store
addr_i32  in  DATA_W  byte address (ALU result in MEM)
write_data_i32  in  DATA_W  store data
read_data_o32  out  DATA_W  load result to MEM/WB; valid when load present and stall_o=0
stall_o  out  1  freeze IF/ID/EX/MEM, bubble into WB
err_o  out  1  one-cycle pulse: misaligned or illegal op dropped
bus_req_o  out  1  bus request
bus_we_o  out  1  1=write, 0=read
bus_addr_o32  out  DATA_W  bus word address (bits[1:0]=0)
bus_wdata_o32  out  DATA_W  bus write data
bus_rdata_i32  in  DATA_W  bus read data, valid with ack
bus_ack_i  in  1  transaction complete

Behaviour:
- Reset (reset_i=0 at a rising edge): state IDLE, buffer empty, and all outputs 0. Reset mid-transaction abandons it; the bus slave must also be reset.
- Bus protocol:
  - One transaction outstanding at a time.
  - bus_req_o, bus_we_o, addr and wdata stay stable from assertion until the cycle bus_ack_i=1, inclusive.
  - An ack in the same cycle as first assertion is legal.
  - bus_req_o drops the cycle after ack unless a new transaction starts.
- Op validity:
  - An op is valid when exactly one of mem_read_i / enable_wmem_i is high.
  - Both high: op dropped, err_o=1, no stall.
  - addr_i32[1:0]!=0: op dropped, err_o=1, read_data_o32=0, no stall.
- Store:
  - Enqueued (addr, data) at the edge where the store is present and stall_o=0. It is enqueued exactly once even if it was presented during earlier stalled cycles.
  - Buffer full: stall_o=1 until an entry drains. The store is then enqueued in the first cycle with a free slot, i.e. the cycle after the draining ack.
- Load hit:
  - Word-address match against any valid buffer entry.
  - read_data_o32 = data of the youngest matching entry, combinational; stall_o=0, zero added latency.
- Load miss, FSM IDLE -> RD_REQ -> RD_DONE -> IDLE:
  - stall_o=1 in IDLE (miss detected) and throughout RD_REQ.
  - On ack, bus_rdata_i32 is captured into rdata_q.
  - RD_DONE: stall_o=0, read_data_o32=rdata_q, pipeline advances; next state IDLE.
  - Minimum miss cost is 2 stall cycles with a same-cycle ack.
- Drain, FSM IDLE -> WR_REQ -> IDLE:
  - Drains the buffer head when the buffer is non-empty and no load miss is pending.
  - The entry is popped at ack.
- Arbitration:
  - A load miss has priority over draining when both are ready in IDLE.
  - A load miss arriving during WR_REQ waits, stalled, for that write's ack, then issues next.
  - Misses never bypass an in-flight write.
- Simultaneous enqueue and pop: legal; occupancy unchanged. Pointers wrap modulo WBUF_DEPTH.
- No MEM op, or buffer not full: stall_o=0 except during a load miss.
- read_data_o32 is 0 when no load is present.

Decomposition:
- Package mem_ctrl_pkg:
  - mem_state_e {IDLE, RD_REQ, RD_DONE, WR_REQ}
  - wbuf_entry_t {addr, data}
  - localparam WORD_OFS=2
- Sub-module wbuf_fifo: circular posted-write FIFO with push/pop/full/empty, head outputs, and a youngest-match lookup port. The lookup is a priority search from tail-1 backwards.

Test Plan:
- Two stores 0x10<-0xAA, 0x14<-0xBB, then no op, ack after 3 cycles each -> no stall; bus writes appear in order 0x10 then 0x14.
- Third store with 2-entry buffer full and ack held low -> stall_o=1 until the first ack; store enqueued the cycle after; exactly 3 bus writes total.
- Store 0x20<-0x11, then store 0x20<-0x22, then load 0x20 before drain -> read_data_o32=0x22, stall_o=0, no bus read.
- Load miss 0x40, slave returns 0xDEADBEEF with same-cycle ack -> stall_o high 2 cycles, then 0xDEADBEEF with stall_o=0 for 1 cycle.
- Load miss 0x80 while WR_REQ of 0x30 is pending ack -> write completes first, then read of 0x80; stall held throughout.
- Load 0x43 -> err_o=1 one cycle, no bus activity. reset_i=0 during RD_REQ -> next cycle bus_req_o=0, stall_o=0, buffer empty.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage bus controller and its posted-write buffer.
package mem_ctrl_pkg;

  localparam int BUS_W    = 32;
  localparam int WORD_OFS = 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_DONE,
    WR_REQ
  } mem_state_e;

  typedef struct packed {
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] data;
  } wbuf_entry_t;

  function automatic logic [BUS_W-1:0] word_align(input logic [BUS_W-1:0] a);
    return {a[BUS_W-1:WORD_OFS], {WORD_OFS{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_wbuf_fifo.sv
// Circular posted-write FIFO with a youngest-entry address lookup used for store-to-load forwarding.
module wbuf_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  wbuf_entry_t      push_entry_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output wbuf_entry_t      head_o,
  input  logic [BUS_W-1:0] lookup_addr_i,
  output logic             hit_o,
  output logic [BUS_W-1:0] hit_data_o
);

  localparam int PW = $clog2(DEPTH);

  wbuf_entry_t   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] idx;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + PW'(1);
    if (do_pop)  head_d = head_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Priority search from tail-1 backwards; the first valid match is the youngest store.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx = tail_q - PW'(k);
      if (!hit_o && ((PW+1)'(k) <= count_q) && (mem_q[idx].addr == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[idx].data;
      end
    end
  end

  // NOTE: entry storage is deliberately not reset; validity comes only from head/tail/count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[tail_q] <= push_entry_i;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: posted store buffer with forwarding, and a one-outstanding bus FSM for misses and drains.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WBUF_DEPTH = 2,
  parameter int DATA_W     = BUS_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              mem_read_i,
  input  logic              enable_wmem_i,
  input  logic [DATA_W-1:0] addr_i32,
  input  logic [DATA_W-1:0] write_data_i32,
  output logic [DATA_W-1:0] read_data_o32,
  output logic              stall_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [DATA_W-1:0] bus_addr_o32,
  output logic [DATA_W-1:0] bus_wdata_o32,
  input  logic [DATA_W-1:0] bus_rdata_i32,
  input  logic              bus_ack_i
);

  mem_state_e        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [DATA_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              misaligned, both_ops, load_v, store_v, load_miss;
  logic              push, pop, full, empty, hit;
  logic [DATA_W-1:0] hit_data;
  wbuf_entry_t       head;

  assign misaligned = (addr_i32[WORD_OFS-1:0] != '0);
  assign both_ops   = mem_read_i & enable_wmem_i;
  assign load_v     = mem_read_i & ~enable_wmem_i & ~misaligned;
  assign store_v    = enable_wmem_i & ~mem_read_i & ~misaligned;
  assign load_miss  = load_v & ~hit;
  assign push       = store_v & ~full;

  assign err_o   = both_ops | ((mem_read_i | enable_wmem_i) & misaligned);
  // A missing load is released in RD_DONE, when rdata_q holds its word.
  assign stall_o = (load_miss & (state_q != RD_DONE)) | (store_v & full);

  always_comb begin
    read_data_o32 = '0;
    if (load_v) read_data_o32 = (state_q == RD_DONE) ? rdata_q : hit_data;
  end

  wbuf_fifo #(
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .push_i       (push),
    .push_entry_i ('{addr: addr_i32, data: write_data_i32}),
    .pop_i        (pop),
    .full_o       (full),
    .empty_o      (empty),
    .head_o       (head),
    .lookup_addr_i(addr_i32),
    .hit_o        (hit),
    .hit_data_o   (hit_data)
  );

  // Bus fields are only loaded when a transaction starts, so they hold stable until its ack.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_miss) begin
          state_d     = RD_REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = word_align(addr_i32);
          bus_wdata_d = '0;
        end else if (!empty) begin
          state_d     = WR_REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = head.addr;
          bus_wdata_d = head.data;
        end
      end
      RD_REQ: begin
        if (bus_ack_i) begin
          state_d   = RD_DONE;
          rdata_d   = bus_rdata_i32;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
        end
      end
      RD_DONE: state_d = IDLE;
      WR_REQ: begin
        if (bus_ack_i) begin
          state_d   = IDLE;
          pop       = 1'b1;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_req_o     = bus_req_q;
  assign bus_we_o      = bus_we_q;
  assign bus_addr_o32  = bus_addr_q;
  assign bus_wdata_o32 = bus_wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed per-cycle vectors for mem_stage_ctrl; a posedge monitor logs every acked bus transfer.
module tb_mem_stage_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        mem_read_i = 1'b0, enable_wmem_i = 1'b0;
  logic [31:0] addr_i32 = '0, write_data_i32 = '0;
  logic [31:0] read_data_o32;
  logic        stall_o, err_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o32, bus_wdata_o32;
  logic [31:0] bus_rdata_i32 = '0;
  logic        bus_ack_i = 1'b0;

  always #5 clk_i = ~clk_i;

  mem_stage_ctrl #(.WBUF_DEPTH(2), .DATA_W(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .mem_read_i(mem_read_i), .enable_wmem_i(enable_wmem_i),
    .addr_i32(addr_i32), .write_data_i32(write_data_i32), .read_data_o32(read_data_o32),
    .stall_o(stall_o), .err_o(err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o32(bus_addr_o32), .bus_wdata_o32(bus_wdata_o32),
    .bus_rdata_i32(bus_rdata_i32), .bus_ack_i(bus_ack_i)
  );

  typedef struct {
    logic        rst, rd, wr;
    logic [31:0] a, wd;
    logic        ack;
    logic [31:0] brd;
    logic        e_stall, e_err, e_req, e_we;
    logic [31:0] e_ba, e_bwd, e_rdata;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic        log_we   [64];
  int          log_n = 0;

  always @(posedge clk_i) begin
    if (reset_i === 1'b1 && bus_req_o === 1'b1 && bus_ack_i === 1'b1 && log_n < 64) begin
      log_addr[log_n] <= bus_addr_o32;
      log_we[log_n]   <= bus_we_o;
      log_data[log_n] <= bus_we_o ? bus_wdata_o32 : bus_rdata_i32;
      log_n           <= log_n + 1;
    end
  end

  function automatic vec_t mk(input logic rd, wr, input logic [31:0] a, wd,
                              input logic ack, input logic [31:0] brd,
                              input logic s, e, rq, we, input logic [31:0] ba, bwd, rdat);
    vec_t v;
    v.rst = 1'b1; v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.ack = ack; v.brd = brd;
    v.e_stall = s; v.e_err = e; v.e_req = rq; v.e_we = we;
    v.e_ba = ba; v.e_bwd = bwd; v.e_rdata = rdat;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset_i = v.rst; mem_read_i = v.rd; enable_wmem_i = v.wr; addr_i32 = v.a;
    write_data_i32 = v.wd; bus_ack_i = v.ack; bus_rdata_i32 = v.brd;
  endtask

  // Bus fields only matter while a request is up; write data only for writes.
  function automatic logic [99:0] obs();
    return {stall_o, err_o, bus_req_o, bus_req_o & bus_we_o,
            bus_req_o ? bus_addr_o32 : 32'h0,
            (bus_req_o & bus_we_o) ? bus_wdata_o32 : 32'h0, read_data_o32};
  endfunction

  function automatic logic [99:0] exp_of(input vec_t v);
    return {v.e_stall, v.e_err, v.e_req, v.e_req & v.e_we,
            v.e_req ? v.e_ba : 32'h0, (v.e_req & v.e_we) ? v.e_bwd : 32'h0, v.e_rdata};
  endfunction

  task automatic test_reset();
    reset_i = 1'b0; mem_read_i = 0; enable_wmem_i = 0; bus_ack_i = 0;
    repeat (2) @(negedge clk_i);
    tests++;
    if ({stall_o, err_o, bus_req_o, bus_we_o, bus_addr_o32, bus_wdata_o32, read_data_o32} !== '0) begin
      $display("FAIL reset_hold: got %h want 0", obs()); fails++;
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    tests++;
    if ({stall_o, err_o, bus_req_o, bus_we_o, bus_addr_o32, bus_wdata_o32, read_data_o32} !== '0) begin
      $display("FAIL reset_release: got %h want 0", obs()); fails++;
    end
  endtask

  task automatic test_two_stores();
    vec_t t[$];
    int base = log_n;
    t.push_back(mk(0,1,32'h10,32'hAA, 0,0, 0,0,0,0, 0,0,0));
    t.push_back(mk(0,1,32'h14,32'hBB, 0,0, 0,0,0,0, 0,0,0));
    t.push_back(mk(0,0,0,0, 0,0, 0,0,1,1, 32'h10,32'hAA,0));
    t.push_back(mk(0,0,0,0, 0,0, 0,0,1,1, 32'h10,32'hAA,0));
    t.push_back(mk(0,0,0,0, 1,0, 0,0,1,1, 32'h10,32'hAA,0));
    t.push_back(mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0));
    t.push_back(mk(0,0,0,0, 0,0, 0,0,1,1, 32'h14,32'hBB,0));
    t.push_back(mk(0,0,0,0, 0,0, 0,0,1,1, 32'h14,32'hBB,0));
    t.push_back(mk(0,0,0,0, 1,0, 0,0,1,1, 32'h14,32'hBB,0));
    t.push_back(mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0));
    t.push_back(mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1;
      tests++;
      if (obs() !== exp_of(t[i])) begin
        $display("FAIL two_stores cyc%0d: got %h want %h", i, obs(), exp_of(t[i])); fails++;
      end
      @(negedge clk_i);
    end
    tests++;
    if (log_n - base !== 2 ||
        {log_we[base], log_addr[base], log_data[base], log_we[base+1], log_addr[base+1], log_data[base+1]}
        !== {1'b1, 32'h10, 32'hAA, 1'b1, 32'h14, 32'hBB}) begin
      $display("FAIL two_stores_bus: got %0d transfers, first %h want 2 writes 0x10 then 0x14", log_n - base, log_addr[base]);
      fails++;
    end
  endtask

  task automatic test_full_store();
    vec_t t[$];
    int base = log_n;
    t.push_back(mk(0,1,32'h50,32'h1, 0,0, 0,0,0,0, 0,0,0));
    t.push_back(mk(0,1,32'h54,32'h2, 0,0, 0,0,0,0, 0,0,0));
    t.push_back(mk(0,1,32'h58,32'h3, 0,0, 1,0,1,1, 32'h50,32'h1,0));
    t.push_back(mk(0,1,32'h58,32'h3, 0,0, 1,0,1,1, 32'h50,32'h1,0));
    t.push_back(mk(0,1,32'h58,32'h3, 1,0, 1,0,1,1, 32'h50,32'h1,0));
    t.push_back(mk(0,1,32'h58,32'h3, 0,0, 0,0,0,0, 0,0,0));
    t.push_back(mk(0,0,0,0, 1,0, 0,0,1,1, 32'h54,32'h2,0));
    t.push_back(mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0));
    t.push_back(mk(0,0,0,0, 1,0, 0,0,1,1, 32'h58,32'h3,0));
    t.push_back(mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0));
    t.push_back(mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1;
      tests++;
      if (obs() !== exp_of(t[i])) begin
        $display("FAIL full_store cyc%0d: got %h want %h", i, obs(), exp_of(t[i])); fails++;
      end
      @(negedge clk_i);
    end
    tests++;
    if (log_n - base !== 3 ||
        {log_addr[base], log_data[base], log_addr[base+1], log_data[base+1], log_addr[base+2], log_data[base+2]}
        !== {32'h50, 32'h1, 32'h54, 32'h2, 32'h58, 32'h3}) begin
      $display("FAIL full_store_bus: got %0d transfers want 3 writes 0x50,0x54,0x58", log_n - base); fails++;
    end
  endtask

  task automatic test_forward();
    vec_t t[$];
    int base = log_n;
    t.push_back(mk(0,1,32'h20,32'h11, 0,0, 0,0,0,0, 0,0,0));
    t.push_back(mk(0,1,32'h20,32'h22, 0,0, 0,0,0,0, 0,0,0));
    t.push_back(mk(1,0,32'h20,0, 0,0, 0,0,1,1, 32'h20,32'h11,32'h22));
    t.push_back(mk(0,0,0,0, 1,0, 0,0,1,1, 32'h20,32'h11,0));
    t.push_back(mk(1,0,32'h20,0, 0,0, 0,0,0,0, 0,0,32'h22));
    t.push_back(mk(0,0,0,0, 1,0, 0,0,1,1, 32'h20,32'h22,0));
    t.push_back(mk(0,0,0,0, 0,0, 0,0,0,0, 0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1;
      tests++;
      if (obs() !== exp_of(t[i])) begin
        $display("FAIL forward cyc%0d: got %h want %h", i, obs(), exp_of(t[i])); fails++;
      end
      @(negedge clk_i);
    end
    tests++;
    if (log_n - base !== 2 || {log_we[base], log_we[base+1], log_data[base], log_data[base+1]}
        !== {1'b1, 1'b1, 32'h11, 32'h22}) begin
      $display("FAIL forward_bus: got %0d transfers want 2 writes and no read", log_n - base); fails++;
    end
  endtask

  task automatic test_load_miss();
    vec_t t[$];
    int base = log_n;
    t.push_back(mk(1,0,32'h40,0, 0,0,            1,0,0,0, 0,0,0));
    t.push_back(mk(1,0,32'h40,0, 1,32'hDEADBEEF, 1,0,1,0, 32'h40,0,0));
    t.push_back(mk(1,0,32'h40,0, 0,0,            0,0,0,0, 0,0,32'hDEADBEEF));
    t.push_back(mk(0,0,0,0, 0,0,                 0,0,0,0, 0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1;
      tests++;
      if (obs() !== exp_of(t[i])) begin
        $display("FAIL load_miss cyc%0d: got %h want %h", i, obs(), exp_of(t[i])); fails++;
      end
      @(negedge clk_i);
    end
    tests++;
    if (log_n - base !== 1 || {log_we[base], log_addr[base], log_data[base]} !== {1'b0, 32'h40, 32'hDEADBEEF}) begin
      $display("FAIL load_miss_bus: got %0d transfers want 1 read of 0x40", log_n - base); fails++;
    end
  endtask

  task automatic test_miss_during_write();
    vec_t t[$];
    int base = log_n;
    t.push_back(mk(0,1,32'h30,32'h33, 0,0,        0,0,0,0, 0,0,0));
    t.push_back(mk(0,0,0,0, 0,0,                  0,0,0,0, 0,0,0));
    t.push_back(mk(1,0,32'h80,0, 0,0,             1,0,1,1, 32'h30,32'h33,0));
    t.push_back(mk(1,0,32'h80,0, 0,0,             1,0,1,1, 32'h30,32'h33,0));
    t.push_back(mk(1,0,32'h80,0, 1,0,             1,0,1,1, 32'h30,32'h33,0));
    t.push_back(mk(1,0,32'h80,0, 0,0,             1,0,0,0, 0,0,0));
    t.push_back(mk(1,0,32'h80,0, 1,32'h12345678,  1,0,1,0, 32'h80,0,0));
    t.push_back(mk(1,0,32'h80,0, 0,0,             0,0,0,0, 0,0,32'h12345678));
    t.push_back(mk(0,0,0,0, 0,0,                  0,0,0,0, 0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1;
      tests++;
      if (obs() !== exp_of(t[i])) begin
        $display("FAIL miss_during_write cyc%0d: got %h want %h", i, obs(), exp_of(t[i])); fails++;
      end
      @(negedge clk_i);
    end
    tests++;
    if (log_n - base !== 2 || {log_we[base], log_addr[base], log_we[base+1], log_addr[base+1]}
        !== {1'b1, 32'h30, 1'b0, 32'h80}) begin
      $display("FAIL miss_during_write_bus: got %0d transfers want write 0x30 then read 0x80", log_n - base); fails++;
    end
  endtask

  task automatic test_err();
    vec_t t[$];
    int base = log_n;
    t.push_back(mk(1,0,32'h43,0, 0,0,   0,1,0,0, 0,0,0));
    t.push_back(mk(0,0,0,0, 0,0,        0,0,0,0, 0,0,0));
    t.push_back(mk(1,1,32'h44,32'h5, 0,0, 0,1,0,0, 0,0,0));
    t.push_back(mk(0,1,32'h46,32'h7, 0,0, 0,1,0,0, 0,0,0));
    t.push_back(mk(0,0,0,0, 0,0,        0,0,0,0, 0,0,0));
    t.push_back(mk(0,0,0,0, 0,0,        0,0,0,0, 0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1;
      tests++;
      if (obs() !== exp_of(t[i])) begin
        $display("FAIL err cyc%0d: got %h want %h", i, obs(), exp_of(t[i])); fails++;
      end
      @(negedge clk_i);
    end
    tests++;
    if (log_n - base !== 0) begin
      $display("FAIL err_bus: got %0d transfers want 0", log_n - base); fails++;
    end
  endtask

  task automatic test_reset_mid();
    vec_t t[$];
    int base = log_n;
    t.push_back(mk(0,1,32'h60,32'h66, 0,0, 0,0,0,0, 0,0,0));
    t.push_back(mk(1,0,32'h90,0, 0,0,      1,0,0,0, 0,0,0));
    t.push_back(mk(1,0,32'h90,0, 0,0,      1,0,1,0, 32'h90,0,0));
    t.push_back(mk(0,0,0,0, 0,0,           0,0,1,0, 32'h90,0,0));
    t[3].rst = 1'b0;
    t.push_back(mk(0,0,0,0, 0,0,           0,0,0,0, 0,0,0));
    t.push_back(mk(1,0,32'h60,0, 0,0,      1,0,0,0, 0,0,0));
    t.push_back(mk(1,0,32'h60,0, 1,32'h5A, 1,0,1,0, 32'h60,0,0));
    t.push_back(mk(1,0,32'h60,0, 0,0,      0,0,0,0, 0,0,32'h5A));
    t.push_back(mk(0,0,0,0, 0,0,           0,0,0,0, 0,0,0));
    t.push_back(mk(0,0,0,0, 0,0,           0,0,0,0, 0,0,0));
    foreach (t[i]) begin
      drive(t[i]); #1;
      tests++;
      if (obs() !== exp_of(t[i])) begin
        $display("FAIL reset_mid cyc%0d: got %h want %h", i, obs(), exp_of(t[i])); fails++;
      end
      @(negedge clk_i);
    end
    tests++;
    if (log_n - base !== 1 || {log_we[base], log_addr[base], log_data[base]} !== {1'b0, 32'h60, 32'h5A}) begin
      $display("FAIL reset_mid_bus: got %0d transfers want only a read of 0x60", log_n - base); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_two_stores();
    test_full_store();
    test_forward();
    test_load_miss();
    test_miss_during_write();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
